// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and round-robin helper for the 4-channel TDM fabric
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {IDLE, SEND} tdm_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr+1, ptr+2, ... ptr+4 (mod 4) and return the first full channel.
  function automatic rr_pick_t rr_next(input logic [NUM_CH-1:0] full,
                                       input logic [SEL_W-1:0]  ptr);
    rr_pick_t         pick;
    logic [SEL_W-1:0] cand;
    pick = '0;
    cand = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = ptr + k[SEL_W-1:0];
      if (!pick.found && full[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tdm_mux4_rr_arb4.sv
// rtl/tdm_mux4_rr_arb4.sv - combinational round-robin picker over four request bits
module rr_arb4
  import tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] full,
  input  logic [SEL_W-1:0]  ptr,
  output logic              grant_valid,
  output logic [SEL_W-1:0]  grant_idx
);

  rr_pick_t pick;

  always_comb begin
    pick        = rr_next(full, ptr);
    grant_valid = pick.found;
    grant_idx   = pick.idx;
  end

endmodule

// File: rtl/tdm_mux4.sv
// rtl/tdm_mux4.sv - four-channel round-robin TDM transmit mux with one-word slot per channel
// Optional even-parity output out_par when TDM_PARITY_EN is defined.
module tdm_mux4
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
`ifdef TDM_PARITY_EN
  ,
  output logic                     out_par
`endif
);

  tdm_state_t        state;
  logic [NUM_CH-1:0] full;
  logic [DATA_W-1:0] slot [NUM_CH];
  logic [SEL_W-1:0]  ptr;

  logic              grant_valid;
  logic [SEL_W-1:0]  grant_idx;
  logic              take;
  logic              do_grant;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] full_nxt;

  rr_arb4 u_arb (
    .full        (full),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Arbitration sees only the registered full bits, so a word captured this
  // cycle competes from the next cycle on. cap and clr never overlap because
  // a slot is only written while it is empty.
  always_comb begin
    take     = (state == IDLE) || out_ready;
    do_grant = take && grant_valid;
    cap      = ch_valid & ~full;
    clr      = '0;
    if (do_grant) begin
      clr[grant_idx] = 1'b1;
    end
    full_nxt = (full | cap) & ~clr;
  end

  assign ch_ready = ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      full      <= '0;
      ptr       <= SEL_W'(NUM_CH - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot[i] <= '0;
      end
`ifdef TDM_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      full <= full_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) begin
          slot[i] <= ch_data[i*DATA_W +: DATA_W];
        end
      end

      case (state)
        IDLE: begin
          if (do_grant) begin
            out_valid <= 1'b1;
            out_data  <= slot[grant_idx];
            out_sel   <= grant_idx;
            ptr       <= grant_idx;
            state     <= SEND;
`ifdef TDM_PARITY_EN
            out_par   <= ^slot[grant_idx];
`endif
          end
        end
        SEND: begin
          if (do_grant) begin
            out_data  <= slot[grant_idx];
            out_sel   <= grant_idx;
            ptr       <= grant_idx;
`ifdef TDM_PARITY_EN
            out_par   <= ^slot[grant_idx];
`endif
          end else if (out_ready) begin
            // Idle outputs are forced to zero so a stale word never lingers.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            state     <= IDLE;
`ifdef TDM_PARITY_EN
            out_par   <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mux4.sv
// tb/tb_tdm_mux4.sv - directed self-checking bench for tdm_mux4
module tb_tdm_mux4;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [3:0]    ch_valid;
  logic [4*DW-1:0] ch_data;
  logic [3:0]    ch_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_ready;
`ifdef TDM_PARITY_EN
  logic          out_par;
`endif

  int n_vec;
  int n_err;

  tdm_mux4 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_ready  (ch_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef TDM_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_sel"},   32'(out_sel),   32'(s));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [1:0] prev_sel;
  logic [1:0] exp_sel;
  logic [7:0] exp_dat;
  logic [7:0] t3 [4];
  logic [7:0] t4 [3];

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    ch_valid  = '0;
    ch_data   = '0;
    out_ready = 1'b0;
    t3[0] = 8'h11; t3[1] = 8'h22; t3[2] = 8'h33; t3[3] = 8'h44;
    t4[0] = 8'h51; t4[1] = 8'h62; t4[2] = 8'h73;

    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ch_ready), 32'hF);
    expect_out("rst", 1'b0, 8'h00, 2'b00);
    step();
    step();
    rst_n = 1'b1;
    step();

    // single word on channel 2
    ch_valid = 4'b0100;
    ch_data[2*DW +: DW] = 8'hA5;
    out_ready = 1'b1;
    step();
    ch_valid = '0;
    check("single_ready_cap", 32'(ch_ready), 32'hB);
    expect_out("single_cap", 1'b0, 8'h00, 2'b00);
    step();
    expect_out("single", 1'b1, 8'hA5, 2'b10);
    check("single_ready_free", 32'(ch_ready), 32'hF);
    step();
    expect_out("single_idle", 1'b0, 8'h00, 2'b00);

    // all four full after reset, drained in order 0..3
    do_reset();
    for (int i = 0; i < 4; i++) ch_data[i*DW +: DW] = t3[i];
    ch_valid = 4'hF;
    step();
    ch_valid = '0;
    check("all_ready_cap", 32'(ch_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("all%0d", i), 1'b1, t3[i], 2'(i));
    end
    step();
    expect_out("all_idle", 1'b0, 8'h00, 2'b00);

    // backpressure: hold 3C for 5 cycles while others fill
    out_ready = 1'b0;
    ch_data[0*DW +: DW] = 8'h3C;
    ch_valid = 4'b0001;
    step();
    ch_valid = 4'b1110;
    for (int i = 0; i < 3; i++) ch_data[(i+1)*DW +: DW] = t4[i];
    step();
    ch_valid = '0;
    check("bp_ready", 32'(ch_ready), 32'h1);
    expect_out("bp_grant", 1'b1, 8'h3C, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("bp_hold%0d", i), 1'b1, 8'h3C, 2'b00);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("bp_drain%0d", i), 1'b1, t4[i], 2'(i + 1));
    end
    step();
    expect_out("bp_idle", 1'b0, 8'h00, 2'b00);

    // fairness/wrap: ch0 and ch3 both streaming, ptr=3 so ch0 first
    ch_data[0*DW +: DW] = 8'hA0;
    ch_data[3*DW +: DW] = 8'hD3;
    ch_valid = 4'b1001;
    step();
    prev_sel = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_sel = (i % 2 == 0) ? 2'b00 : 2'b11;
      exp_dat = (i % 2 == 0) ? 8'hA0 : 8'hD3;
      expect_out($sformatf("rr%0d", i), 1'b1, exp_dat, exp_sel);
      if (i > 0) check($sformatf("rr_norep%0d", i), 32'(out_sel == prev_sel), 32'h0);
      prev_sel = out_sel;
    end

    // reset asserted mid-burst acts before any clock edge
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ch_ready), 32'hF);
    expect_out("midrst", 1'b0, 8'h00, 2'b00);
    ch_valid = '0;
    step();
    rst_n = 1'b1;
    step();
    expect_out("post_rst", 1'b0, 8'h00, 2'b00);

    // parity vectors
    ch_data[0*DW +: DW] = 8'h07;
    ch_valid = 4'b0001;
    step();
    ch_valid = '0;
    step();
    expect_out("par07", 1'b1, 8'h07, 2'b00);
`ifdef TDM_PARITY_EN
    check("par07_par", 32'(out_par), 32'h1);
`endif
    ch_data[0*DW +: DW] = 8'h03;
    ch_valid = 4'b0001;
    step();
    ch_valid = '0;
    expect_out("par_gap", 1'b0, 8'h00, 2'b00);
`ifdef TDM_PARITY_EN
    check("par_gap_par", 32'(out_par), 32'h0);
`endif
    step();
    expect_out("par03", 1'b1, 8'h03, 2'b00);
`ifdef TDM_PARITY_EN
    check("par03_par", 32'(out_par), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
